hazard_flush_controller: RTL and testbench
==========================================

# hazard_flush_controller

Central pipeline sequencer for the 5-stage core. It arbitrates three competing control sources: data-memory back-pressure, load-use hazards and ID-stage branch mispredictions from `branch_prediction_unit`. It drives the single `stall`, `flush_IF`, `bubble_EX` and `pc_sel` controls seen by the PC, the IF/ID and ID/EX registers, and the predictor. A small FSM guarantees exactly one bubble per load-use hazard and a clean freeze during memory waits.

## Interface
- `MEM_TIMEOUT`, default 255: consecutive `dmem_busy` cycles before `mem_timeout` is raised; legal range 1..65535.
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `branch_prediction`  in  1  IF-stage predicted-taken from `branch_prediction_unit`.
- `branch_redo`  in  1  ID-stage misprediction from `branch_prediction_unit`.
- `rs1_ID`, `rs2_ID`  in  5 each  source registers of the ID-stage instruction.
- `rd_EX`  in  5  destination register of the EX-stage instruction.
- `mem_read_EX`  in  1  EX-stage instruction is a load.
- `dmem_busy`  in  1  data memory not ready; the whole pipe must hold.
- `pc_sel`  out  2  `PcSel_t`: `PC_PLUS4`=0, `PC_PREDICT`=1, `PC_REDO`=2.
- `stall`  out  1  freeze PC and IF/ID; also feeds `branch_prediction_unit.stall`.
- `flush_IF`  out  1  squash IF/ID on the next edge (inserts `M_ADD`-encoded NOP).
- `bubble_EX`  out  1  load NOP into ID/EX on the next edge.
- `mem_timeout`  out  1  sticky watchdog flag.
- `mispredict_count`, `stall_cycles`  out  32 each  performance counters.

## Operation
- FSM `CtrlState_t` has three states: `RUN`, `LOAD_STALL`, `MEM_WAIT`. The reset state is `RUN`.
- Hazard condition `hz` = `mem_read_EX` && `rd_EX`≠0 && (`rd_EX`==`rs1_ID` || `rd_EX`==`rs2_ID`).
- Priority in every state, highest first: `dmem_busy` > `hz` > `branch_redo` > `branch_prediction`.
- **RUN**
  - If `dmem_busy`: `stall`=1, all other controls idle, go to `MEM_WAIT`.
  - Else if `hz`: `stall`=1, `bubble_EX`=1, go to `LOAD_STALL`. A `branch_redo` in the same cycle is ignored, because its operands are stale; it re-evaluates next cycle.
  - Else if `branch_redo`: `pc_sel`=`PC_REDO`, `flush_IF`=1, stay in `RUN`.
  - Else `pc_sel` = `branch_prediction` ? `PC_PREDICT` : `PC_PLUS4`.
- **LOAD_STALL**
  - `hz` is not re-checked, since EX now holds the bubble.
  - Otherwise the same decode as `RUN` (`dmem_busy` → `MEM_WAIT`; `branch_redo` honoured), then return to `RUN`.
- **MEM_WAIT**
  - `stall`=1, `flush_IF`=0, `bubble_EX`=0, `pc_sel`=`PC_PLUS4`.
  - Leave for `RUN` on the first cycle with `dmem_busy`=0. That cycle is decoded as `RUN`.
- **Watchdog**
  - `busy_cnt` has width $clog2(MEM_TIMEOUT+1) and saturates at `MEM_TIMEOUT`.
  - It increments while `dmem_busy`=1 and clears when `dmem_busy`=0.
  - `mem_timeout` sets when `busy_cnt` reaches `MEM_TIMEOUT`. It is cleared only by reset.

## Timing
- All outputs are combinational from the state and the current inputs (Mealy); the PC and pipe registers act on the next edge.
- Load-use penalty: exactly 1 cycle. Mispredict penalty: 1 cycle, since the IF instruction is squashed and the redirect PC is loaded on the same edge.
- `mem_timeout` rises on the edge where the `MEM_TIMEOUT`-th consecutive busy cycle ends.
- Reset is asynchronous:
  - While `reset_n`=0, every output is forced idle: `stall`=0, `flush_IF`=0, `bubble_EX`=0, `pc_sel`=`PC_PLUS4`, `mem_timeout`=0, counters=0.
  - The FSM returns to `RUN` immediately, including mid-`MEM_WAIT` or mid-`LOAD_STALL`.

## Configuration
- Macro `HFC_PERF_COUNTERS_EN`.
- When defined:
  - `mispredict_count` increments on each honoured `branch_redo`.
  - `stall_cycles` increments on each cycle with `stall`=1.
  - Both counters are 32-bit and saturate at 0xFFFF_FFFF.
- When undefined: both ports remain and are tied to 0. No counter flops are synthesised.

## Structure
- `package_project_typedefs` gains the following; opcode constants (`M_*`) are reused unchanged:
  - `PcSel_t` with `PC_PLUS4`, `PC_PREDICT`, `PC_REDO`.
  - `CtrlState_t` with `RUN`, `LOAD_STALL`, `MEM_WAIT`.
- One sub-module, `sat_counter` (parameterised width, increment enable, async active-low clear). It is used for the watchdog and for both performance counters.

## Test plan
- Reset: hold `reset_n`=0 with `dmem_busy`=1 and `branch_redo`=1 → all outputs idle, state `RUN`.
- Load-use: `mem_read_EX`=1, `rd_EX`=5, `rs2_ID`=5 → one cycle of `stall`=1 and `bubble_EX`=1, then `stall`=0 the next cycle even if the inputs are unchanged.
- Hazard vs redo: `hz` and `branch_redo` both high → redo ignored (`pc_sel`=`PC_PLUS4`). With `branch_redo` still 1 next cycle → `pc_sel`=`PC_REDO`, `flush_IF`=1, `mispredict_count`=1.
- Memory freeze: `dmem_busy`=1 for 3 cycles with `branch_prediction`=1 → `stall`=1 for 3 cycles, `pc_sel`=`PC_PLUS4` throughout, `stall_cycles`=3. The 4th cycle gives `pc_sel`=`PC_PREDICT`.
- Watchdog: `MEM_TIMEOUT`=4 with `dmem_busy` held 4 cycles → `mem_timeout`=1. Dropping `dmem_busy` leaves it at 1; pulsing `reset_n` low clears it.
- `r0` exemption: `mem_read_EX`=1, `rd_EX`=0, `rs1_ID`=0 → no stall, `pc_sel` follows `branch_prediction`.

Source files
------------

// File: rtl/hazard_flush_controller_pkg.sv
// rtl/hazard_flush_controller_pkg.sv - shared pipeline-control types and the load-use hazard test
package package_project_typedefs;

  typedef enum logic [1:0] {
    PC_PLUS4   = 2'd0,
    PC_PREDICT = 2'd1,
    PC_REDO    = 2'd2
  } PcSel_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } CtrlState_t;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  function automatic logic load_use_hazard(
    input logic       mem_read_ex,
    input logic [4:0] rd_ex,
    input logic [4:0] rs1_id,
    input logic [4:0] rs2_id
  );
    return mem_read_ex && (rd_ex != 5'd0) && ((rd_ex == rs1_id) || (rd_ex == rs2_id));
  endfunction

endpackage

// File: rtl/hazard_flush_controller_sat_counter.sv
// rtl/hazard_flush_controller_sat_counter.sv - up-counter saturating at MAX, async clear plus sync clear
module sat_counter #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             i_en,
  input  logic             i_sync_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_count <= '0;
    end else if (i_sync_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_flush_controller.sv
// rtl/hazard_flush_controller.sv - pipeline stall/flush/bubble sequencer; HFC_PERF_COUNTERS_EN adds perf counters
module hazard_flush_controller
  import package_project_typedefs::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        branch_prediction,
  input  logic        branch_redo,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic [4:0]  rd_EX,
  input  logic        mem_read_EX,
  input  logic        dmem_busy,
  output PcSel_t      pc_sel,
  output logic        stall,
  output logic        flush_IF,
  output logic        bubble_EX,
  output logic        mem_timeout,
  output logic [31:0] mispredict_count,
  output logic [31:0] stall_cycles
);

  localparam int            BW  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BW-1:0] TMO = BW'(MEM_TIMEOUT);

  CtrlState_t    r_state;
  CtrlState_t    w_next;
  logic          w_hz;
  logic          w_stall;
  logic          w_flush;
  logic          w_bubble;
  PcSel_t        w_pc;
  logic [BW-1:0] w_busy_cnt;
  logic          r_mem_timeout;

  assign w_hz = load_use_hazard(mem_read_EX, rd_EX, rs1_ID, rs2_ID);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // MEM_WAIT with memory ready decodes exactly like RUN; LOAD_STALL only masks hz.
  always_comb begin
    w_next   = RUN;
    w_stall  = 1'b0;
    w_flush  = 1'b0;
    w_bubble = 1'b0;
    w_pc     = PC_PLUS4;
    if (dmem_busy) begin
      w_stall = 1'b1;
      w_next  = MEM_WAIT;
    end else if (w_hz && (r_state != LOAD_STALL)) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
      w_next   = LOAD_STALL;
    end else if (branch_redo) begin
      w_flush = 1'b1;
      w_pc    = PC_REDO;
    end else if (branch_prediction) begin
      w_pc = PC_PREDICT;
    end
  end

  assign stall     = reset_n & w_stall;
  assign flush_IF  = reset_n & w_flush;
  assign bubble_EX = reset_n & w_bubble;
  assign pc_sel    = reset_n ? w_pc : PC_PLUS4;

  sat_counter #(
    .WIDTH (BW),
    .MAX   (TMO)
  ) u_busy_cnt (
    .clk        (clk),
    .clr_n      (reset_n),
    .i_en       (dmem_busy),
    .i_sync_clr (!dmem_busy),
    .o_count    (w_busy_cnt)
  );

  // Set on the edge that closes the MEM_TIMEOUT-th consecutive busy cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_timeout <= 1'b0;
    end else if (dmem_busy && (w_busy_cnt >= (TMO - BW'(1)))) begin
      r_mem_timeout <= 1'b1;
    end
  end

  assign mem_timeout = r_mem_timeout;

`ifdef HFC_PERF_COUNTERS_EN
  sat_counter #(
    .WIDTH (32)
  ) u_mispredict_cnt (
    .clk        (clk),
    .clr_n      (reset_n),
    .i_en       (w_flush),
    .i_sync_clr (1'b0),
    .o_count    (mispredict_count)
  );

  sat_counter #(
    .WIDTH (32)
  ) u_stall_cnt (
    .clk        (clk),
    .clr_n      (reset_n),
    .i_en       (w_stall),
    .i_sync_clr (1'b0),
    .o_count    (stall_cycles)
  );
`else
  assign mispredict_count = 32'd0;
  assign stall_cycles     = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_flush_controller.sv
// tb/tb_hazard_flush_controller.sv - randomized and directed checks against a cycle-level behavioural model
module tb_hazard_flush_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        branch_prediction;
  logic        branch_redo;
  logic [4:0]  rs1_ID;
  logic [4:0]  rs2_ID;
  logic [4:0]  rd_EX;
  logic        mem_read_EX;
  logic        dmem_busy;
  logic [1:0]  pc_sel;
  logic        stall;
  logic        flush_IF;
  logic        bubble_EX;
  logic        mem_timeout;
  logic [31:0] mispredict_count;
  logic [31:0] stall_cycles;

  int n_total = 0;
  int n_bad   = 0;

  // Model state: did the previous cycle insert a bubble, length of the current busy run.
  bit m_bubbled_last;
  int m_busy_run;
  bit m_timeout;
  int m_mispredicts;
  int m_stall_cycles;

  localparam int TMO = 4;

  always #5 clk = ~clk;

  hazard_flush_controller #(
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .branch_prediction (branch_prediction),
    .branch_redo       (branch_redo),
    .rs1_ID            (rs1_ID),
    .rs2_ID            (rs2_ID),
    .rd_EX             (rd_EX),
    .mem_read_EX       (mem_read_EX),
    .dmem_busy         (dmem_busy),
    .pc_sel            (pc_sel),
    .stall             (stall),
    .flush_IF          (flush_IF),
    .bubble_EX         (bubble_EX),
    .mem_timeout       (mem_timeout),
    .mispredict_count  (mispredict_count),
    .stall_cycles      (stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check the Mealy outputs, then advance the model at the rising edge.
  task automatic step(input logic rn, input logic bp, input logic br, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [4:0] rd, input logic mrd, input logic busy);
    bit hz, e_stall, e_flush, e_bubble;
    logic [1:0] e_pc;
    @(negedge clk);
    reset_n = rn; branch_prediction = bp; branch_redo = br;
    rs1_ID = r1; rs2_ID = r2; rd_EX = rd; mem_read_EX = mrd; dmem_busy = busy;
    if (!rn) begin
      m_bubbled_last = 0; m_busy_run = 0; m_timeout = 0; m_mispredicts = 0; m_stall_cycles = 0;
    end
    hz = mrd && (rd != 0) && (rd == r1 || rd == r2);
    e_stall = 0; e_flush = 0; e_bubble = 0; e_pc = 2'd0;
    if (rn) begin
      if (busy) e_stall = 1;
      else if (hz && !m_bubbled_last) begin e_stall = 1; e_bubble = 1; end
      else if (br) begin e_flush = 1; e_pc = 2'd2; end
      else if (bp) e_pc = 2'd1;
    end
    #1;
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush_IF", 32'(flush_IF), 32'(e_flush));
    chk("bubble_EX", 32'(bubble_EX), 32'(e_bubble));
    chk("pc_sel", 32'(pc_sel), 32'(e_pc));
    chk("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
`ifdef HFC_PERF_COUNTERS_EN
    chk("mispredict_count", mispredict_count, 32'(m_mispredicts));
    chk("stall_cycles", stall_cycles, 32'(m_stall_cycles));
`else
    chk("mispredict_count", mispredict_count, 32'd0);
    chk("stall_cycles", stall_cycles, 32'd0);
`endif
    @(posedge clk);
    if (rn) begin
      m_bubbled_last = e_bubble;
      m_busy_run = busy ? ((m_busy_run < TMO) ? m_busy_run + 1 : TMO) : 0;
      if (m_busy_run >= TMO) m_timeout = 1;
      if (e_flush) m_mispredicts++;
      if (e_stall) m_stall_cycles++;
    end
  endtask

  initial begin
    reset_n = 0; branch_prediction = 0; branch_redo = 0;
    rs1_ID = 0; rs2_ID = 0; rd_EX = 0; mem_read_EX = 0; dmem_busy = 0;
    m_bubbled_last = 0; m_busy_run = 0; m_timeout = 0; m_mispredicts = 0; m_stall_cycles = 0;

    // Reset holds everything idle despite busy and redo.
    repeat (2) step(0, 1, 1, 5'd0, 5'd0, 5'd0, 0, 1);
    step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);

    // Load-use: one bubble, then no stall with inputs unchanged, then hazard seen again.
    repeat (3) step(1, 0, 0, 5'd1, 5'd5, 5'd5, 1, 0);
    // Hazard masks redo; redo honoured next cycle.
    step(1, 0, 1, 5'd7, 5'd2, 5'd7, 1, 0);
    step(1, 0, 1, 5'd7, 5'd2, 5'd7, 1, 0);
    step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);

    // Memory freeze with prediction pending.
    repeat (3) step(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    step(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);

    // Watchdog: 3 busy cycles are not enough, 4 are; flag is sticky until reset.
    repeat (3) step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    repeat (4) step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1);
    repeat (2) step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);

    // x0 exemption.
    step(1, 1, 0, 5'd0, 5'd3, 5'd0, 1, 0);
    step(1, 0, 0, 5'd0, 5'd0, 5'd0, 1, 0);

    // Reset mid-LOAD_STALL must return to RUN so the still-present hazard stalls again.
    step(1, 0, 0, 5'd9, 5'd0, 5'd9, 1, 0);
    step(0, 0, 0, 5'd9, 5'd0, 5'd9, 1, 0);
    step(1, 0, 0, 5'd9, 5'd0, 5'd9, 1, 0);

    // Randomized traffic with small register space, busy bursts and rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic rn, busy;
      rn   = ($urandom_range(0, 199) != 0);
      busy = ($urandom_range(0, 5) == 0) || (dmem_busy && $urandom_range(0, 3) != 0);
      step(rn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), busy);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
